// File: rtl/frame_unpacker.sv
// Receive-side filler deframer: hunts and tracks the 44-bit marker cycle, strips markers and
// repacks each 16x11-bit data group into eleven 16-bit words. Optional stats: FRAME_UNPACKER_STATS_EN.
module frame_unpacker #(
   parameter int MAX_GROUPS = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] inWord,
   input  logic        inValid,
   output logic        inReady,
   output logic [15:0] outWord,
   output logic        outValid,
   output logic        locked,
   output logic [1:0]  markerIdx,
   output logic        markerErr,
   output logic        lockLost
`ifdef FRAME_UNPACKER_STATS_EN
   ,
   output logic [15:0] markerCnt,
   output logic [15:0] errCnt
`endif
);

   localparam int GW = $clog2(MAX_GROUPS + 1);
   localparam logic [30:0] M = 31'b1111100110100100001010111011000;
   localparam logic [12:0] B = 13'b1111100110101;
   localparam logic [43:0] MK0 = {M, B};
   localparam logic [43:0] MK1 = {~M, B};
   localparam logic [43:0] MK2 = {M, ~B};
   localparam logic [43:0] MK3 = {~M, ~B};

   typedef enum logic [1:0] {HUNT, MCHK, GROUP, UNPACK} state_t;
   state_t state, nextState;

   logic [32:0]       win;
   logic [2:0]        fill;
   logic [15:0][10:0] acc;
   logic [10:0][15:0] outView;
   logic [3:0]        wcnt, ucnt;
   logic [GW-1:0]     grpCnt;
   logic [1:0]        expected;
   logic              accept, hit;
   logic [1:0]        hitIdx;
   logic [43:0]       cmpWin;
   logic              huntLock, mchkMarker, mchkData, groupDone, unpackDone, lossNow;
   logic              unusedBit;

   assign unusedBit = inWord[11];
   assign inReady   = (state != UNPACK);
   assign accept    = inValid & inReady;
   // acc slot 15 holds the first word of the group, so the flat 176-bit view is MSB-first
   assign outView   = acc;

   // One matcher serves both the hunting window and the group-head check
   always_comb begin
      cmpWin = (state == HUNT) ? {win, inWord[10:0]} : {acc[15:13], inWord[10:0]};
      hit    = 1'b1;
      hitIdx = 2'd0;
      if (cmpWin == MK0)      hitIdx = 2'd0;
      else if (cmpWin == MK1) hitIdx = 2'd1;
      else if (cmpWin == MK2) hitIdx = 2'd2;
      else if (cmpWin == MK3) hitIdx = 2'd3;
      else                    hit    = 1'b0;
   end

   assign huntLock   = (state == HUNT) && accept && (fill >= 3'd3) && hit;
   assign mchkMarker = (state == MCHK) && accept && (wcnt == 4'd3) && hit;
   assign mchkData   = (state == MCHK) && accept && (wcnt == 4'd3) && !hit;
   assign groupDone  = (state == GROUP) && accept && (wcnt == 4'd15);
   assign unpackDone = (state == UNPACK) && (ucnt == 4'd10);
   assign lossNow    = unpackDone && (grpCnt >= GW'(MAX_GROUPS));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= HUNT;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         HUNT:    if (huntLock)   nextState = MCHK;
         MCHK:    if (mchkData)   nextState = GROUP;
         GROUP:   if (groupDone)  nextState = UNPACK;
         UNPACK:  if (unpackDone) nextState = lossNow ? HUNT : MCHK;
         default:                 nextState = HUNT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win       <= '0;
         fill      <= '0;
         acc       <= '0;
         wcnt      <= '0;
         ucnt      <= '0;
         grpCnt    <= '0;
         expected  <= '0;
         outWord   <= '0;
         outValid  <= 1'b0;
         locked    <= 1'b0;
         markerIdx <= '0;
         markerErr <= 1'b0;
         lockLost  <= 1'b0;
      end else begin
         outValid  <= 1'b0;
         markerErr <= 1'b0;
         lockLost  <= 1'b0;
         if (state == HUNT && accept) begin
            win <= {win[21:0], inWord[10:0]};
            if (fill != 3'd4) fill <= fill + 3'd1;
         end
         if ((state == MCHK || state == GROUP) && accept) begin
            acc[4'd15 - wcnt] <= inWord[10:0];
            wcnt              <= wcnt + 4'd1;
         end
         if (huntLock || mchkMarker) begin
            locked    <= 1'b1;
            markerIdx <= hitIdx;
            expected  <= hitIdx + 2'd1;
            grpCnt    <= '0;
            wcnt      <= '0;
            markerErr <= mchkMarker && (hitIdx != expected);
         end
         if (groupDone) begin
            grpCnt <= grpCnt + 1'b1;
            wcnt   <= '0;
            ucnt   <= '0;
         end
         if (state == UNPACK) begin
            outWord  <= outView[4'd10 - ucnt];
            outValid <= 1'b1;
            ucnt     <= unpackDone ? 4'd0 : ucnt + 4'd1;
         end
         // A fresh hunt must see four new words before it can match
         if (lossNow) begin
            locked   <= 1'b0;
            lockLost <= 1'b1;
            fill     <= '0;
         end
      end
   end

`ifdef FRAME_UNPACKER_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         markerCnt <= '0;
         errCnt    <= '0;
      end else begin
         if (mchkMarker) markerCnt <= markerCnt + 16'd1;
         if ((mchkMarker && (hitIdx != expected)) || lossNow) errCnt <= errCnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_frame_unpacker.sv
// Bench for frame_unpacker: queue-based framing model, per-cycle compare, directed scenarios plus random traffic.
module tb_frame_unpacker;

   localparam int MAXG = 24;
   localparam logic [30:0] M = 31'b1111100110100100001010111011000;
   localparam logic [12:0] B = 13'b1111100110101;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] inWord;
   logic        inValid;
   logic        inReady, outValid, locked, markerErr, lockLost;
   logic [15:0] outWord;
   logic [1:0]  markerIdx;
`ifdef FRAME_UNPACKER_STATS_EN
   logic [15:0] markerCnt, errCnt;
`endif

   int errors = 0;
   int checks = 0;
   int capQ[$];
   int errSeen = 0;
   int lostSeen = 0;

   // Model: word queues and flags describing the framing, not the datapath
   int         winQ[$], colQ[$], pendQ[$];
   int         mGroups;
   bit         mHunt, mLocked, mLossPend;
   logic [1:0] mIdx, mExp;
   bit         expReady, expOutValid, expErr, expLost, lastAccept;
   logic [15:0] expOutWord;

   always #5 clk = ~clk;

   frame_unpacker #(.MAX_GROUPS(MAXG)) dut (
`ifdef FRAME_UNPACKER_STATS_EN
      .markerCnt(markerCnt),
      .errCnt(errCnt),
`endif
      .clk(clk),
      .reset(reset),
      .inWord(inWord),
      .inValid(inValid),
      .inReady(inReady),
      .outWord(outWord),
      .outValid(outValid),
      .locked(locked),
      .markerIdx(markerIdx),
      .markerErr(markerErr),
      .lockLost(lockLost)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [43:0] markerOf(input int k);
      logic [30:0] m;
      logic [12:0] b;
      m = ((k & 1) != 0) ? ~M : M;
      b = ((k & 2) != 0) ? ~B : B;
      return {m, b};
   endfunction

   function automatic int matchQ(input int q[$]);
      logic [43:0] v;
      v = {11'(q[0]), 11'(q[1]), 11'(q[2]), 11'(q[3])};
      for (int k = 0; k < 4; k++) if (v == markerOf(k)) return k;
      return -1;
   endfunction

   task automatic mReset();
      winQ.delete(); colQ.delete(); pendQ.delete();
      mGroups = 0; mHunt = 1; mLocked = 0; mLossPend = 0;
      mIdx = 2'd0; mExp = 2'd0;
      expReady = 1; expOutValid = 0; expOutWord = 16'd0;
      expErr = 0; expLost = 0; lastAccept = 0;
   endtask

   task automatic consume(input int w);
      int k;
      if (mHunt) begin
         winQ.push_back(w);
         if (winQ.size() > 4) void'(winQ.pop_front());
         if (winQ.size() == 4) begin
            k = matchQ(winQ);
            if (k >= 0) begin
               mHunt = 0; mLocked = 1; mIdx = 2'(k); mExp = 2'(k + 1);
               mGroups = 0; colQ.delete();
            end
         end
      end else begin
         colQ.push_back(w);
         if (colQ.size() == 4) begin
            k = matchQ(colQ);
            if (k >= 0) begin
               expErr = (2'(k) != mExp);
               mIdx = 2'(k); mExp = 2'(k + 1); mGroups = 0;
               colQ.delete();
            end
         end
         if (colQ.size() == 16) begin
            logic [175:0] bits;
            bits = '0;
            foreach (colQ[i]) bits = {bits[164:0], 11'(colQ[i])};
            for (int j = 0; j < 11; j++) pendQ.push_back(int'(bits[175 - 16*j -: 16]));
            colQ.delete();
            mGroups++;
            if (mGroups >= MAXG) mLossPend = 1;
         end
      end
   endtask

   // Model advances on the same edges as the DUT, from the bench-driven inputs only
   always @(posedge clk or posedge reset) begin
      if (reset) mReset();
      else begin
         expErr = 0; expLost = 0; lastAccept = 0;
         if (pendQ.size() > 0) begin
            expOutValid = 1;
            expOutWord  = 16'(pendQ.pop_front());
            if (pendQ.size() == 0 && mLossPend) begin
               expLost = 1; mLocked = 0; mHunt = 1; mLossPend = 0; winQ.delete();
            end
         end else begin
            expOutValid = 0;
            if (inValid) begin
               lastAccept = 1;
               consume(int'(inWord[10:0]));
            end
         end
         expReady = (pendQ.size() == 0);
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("inReady", inReady, expReady);
         chk("outValid", outValid, expOutValid);
         if (expOutValid) chk("outWord", outWord, expOutWord);
         chk("locked", locked, mLocked);
         chk("markerIdx", markerIdx, mIdx);
         chk("markerErr", markerErr, expErr);
         chk("lockLost", lockLost, expLost);
         if (outValid) capQ.push_back(int'(outWord));
         errSeen  += int'(markerErr);
         lostSeen += int'(lockLost);
      end
   end

   // Garbage is presented whenever the block is expected to be stalled
   task automatic sendWord(input logic [10:0] w);
      int n;
      n = 0;
      if ($urandom_range(0, 3) == 0) begin
         inValid = 1'b0;
         inWord  = 12'($urandom);
         @(negedge clk);
      end
      do begin
         inValid = 1'b1;
         inWord  = expReady ? {1'($urandom), w} : 12'($urandom);
         @(negedge clk);
         n++;
      end while (!lastAccept && n < 100);
      chk("wordAccepted", lastAccept, 1'b1);
      inValid = 1'b0;
   endtask

   task automatic sendPart(input int k, input int from, input int upto);
      logic [43:0] v;
      v = markerOf(k);
      for (int j = from; j < upto; j++) sendWord(v[43 - 11*j -: 11]);
   endtask

   task automatic sendBits(input logic [175:0] v);
      for (int j = 0; j < 16; j++) sendWord(v[175 - 11*j -: 11]);
   endtask

   task automatic sendRandGroup();
      logic [175:0] v;
      v = '0;
      for (int i = 0; i < 11; i++) v = {v[159:0], 16'($urandom)};
      sendBits(v);
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: run did not complete by %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      logic [175:0] v;
      int eb, lb;
      reset = 1'b1; inValid = 1'b0; inWord = '0;
      repeat (2) @(negedge clk);
      chk("rstReady", inReady, 1'b1);
      chk("rstValid", outValid, 1'b0);
      chk("rstLocked", locked, 1'b0);
      chk("rstIdx", markerIdx, 2'd0);
      #2 reset = 1'b0;
      @(negedge clk);

      // lock acquired from hunt on the 4th marker word
      repeat (3) sendWord(11'($urandom));
      sendPart(0, 0, 3);
      chk("preLock", locked, 1'b0);
      sendPart(0, 3, 4);
      chk("huntLocked", locked, 1'b1);
      chk("huntIdx", markerIdx, 2'd0);

      // pack 0x0001..0x000B and expect it back in order
      v = '0;
      for (int i = 0; i < 11; i++) v = {v[159:0], 16'(i + 1)};
      capQ.delete();
      sendBits(v);
      for (int c = 0; c < 11; c++) begin
         chk("unpackReady", inReady, 1'b0);
         @(negedge clk);
      end
      chk("readyBack", inReady, 1'b1);
      @(negedge clk);
      chk("unpackCount", capQ.size(), 11);
      foreach (capQ[i]) chk("unpackWord", capQ[i], i + 1);

      // variants 0,1,3: one error at 3, then 0 is the expected successor
      eb = errSeen;
      sendPart(1, 0, 4);
      sendPart(3, 0, 4);
      @(negedge clk);
      chk("errPulses", errSeen - eb, 1);
      chk("idxAfter3", markerIdx, 2'd3);
      sendPart(0, 0, 4);
      @(negedge clk);
      chk("errAfterWrap", errSeen - eb, 1);
      chk("idxAfter0", markerIdx, 2'd0);

      // lock loss after MAXG groups without a marker
      lb = lostSeen;
      repeat (MAXG - 1) sendRandGroup();
      repeat (12) @(negedge clk);
      chk("stillLocked", locked, 1'b1);
      chk("noLossYet", lostSeen - lb, 0);
      sendRandGroup();
      repeat (12) @(negedge clk);
      chk("lossPulse", lostSeen - lb, 1);
      chk("lossUnlocked", locked, 1'b0);
      chk("lossReady", inReady, 1'b1);

      // reset in the middle of an unpack burst
      repeat (3) sendWord(11'($urandom));
      sendPart(2, 0, 4);
      chk("relockIdx", markerIdx, 2'd2);
      sendRandGroup();
      repeat (5) @(negedge clk);
      chk("midUnpackValid", outValid, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("asyncValid", outValid, 1'b0);
      chk("asyncLocked", locked, 1'b0);
      chk("asyncReady", inReady, 1'b1);
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      sendPart(0, 1, 4);
      chk("partialNoLock", locked, 1'b0);
      sendPart(0, 0, 4);
      chk("fullRelock", locked, 1'b1);

      // random mix of markers, groups and misaligning stray words
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: sendPart(int'($urandom_range(0, 3)), 0, 4);
            9:       repeat ($urandom_range(1, 3)) sendWord(11'($urandom));
            default: sendRandGroup();
         endcase
      end
      repeat (15) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
